// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives the instruction memory read port,
// buffers fetched words in a small FIFO and hands {pc, instr} to decode. Optional: FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [31:0] imem_addr_o,
    output logic        imem_en_o,
    input  logic [31:0] imem_instr_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        halt_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        misalign_o
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_WAIT,
        S_RUN,
        S_HALT
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        S_TRAP
`endif
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [31:0]     pc;
    logic [CW-1:0]   count;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            redir;
    logic            fetch;
    logic            pop;
    logic            vld_p1;
    logic [31:0]     redir_target;

    logic [31:0]     fifo_pc_p1    [FIFO_DEPTH];
    logic [31:0]     fifo_instr_p1 [FIFO_DEPTH];

    // Redirects are ignored in the single WAIT cycle after reset.
    assign redir = redirect_i && (state != S_WAIT);
    assign fetch = (state == S_RUN) && !halt_i && !redirect_i && (count < CW'(FIFO_DEPTH));
    assign pop   = vld_p1 && ready_i && !redirect_i;

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned targets are loaded verbatim so the trapping address stays visible.
    assign redir_target = redirect_pc_i;
    assign vld_p1       = (count != '0) && (state != S_TRAP);
`else
    assign redir_target = {redirect_pc_i[31:2], 2'b00};
    assign vld_p1       = (count != '0);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT:  state_nxt = S_RUN;
            S_RUN:   if (halt_i) state_nxt = S_HALT;
            S_HALT:  if (!halt_i) state_nxt = S_RUN;
            default: state_nxt = state;
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        if (redir) begin
            if (redirect_pc_i[1:0] != 2'b00)
                state_nxt = S_TRAP;
            else if (state == S_TRAP)
                state_nxt = S_RUN;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= S_WAIT;
            pc     <= RESET_PC;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (redir) begin
                pc     <= redir_target;
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (fetch) begin
                    pc     <= pc + 32'd4;
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (fetch && !pop)
                    count <= count + 1'b1;
                else if (!fetch && pop)
                    count <= count - 1'b1;
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            misalign_o <= 1'b0;
        else if (redir)
            misalign_o <= (redirect_pc_i[1:0] != 2'b00);
    end
`endif

    // Stage p1: fetched word captured in the FIFO; occupancy is tracked by count.
    always_ff @(posedge clk_i) begin
        if (fetch) begin
            fifo_pc_p1[wr_ptr]    <= pc;
            fifo_instr_p1[wr_ptr] <= imem_instr_i;
        end
    end

    assign imem_addr_o = pc;
    assign imem_en_o   = fetch;
    assign valid_o     = vld_p1;
    assign instr_o     = vld_p1 ? fifo_instr_p1[rd_ptr] : NOP_INSTR;
    assign pc_o        = vld_p1 ? fifo_pc_p1[rd_ptr] : 32'h0000_0000;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch initiator that drives the instruction memory's read port: owns the PC and issues word addresses with a fetch enable.
- Captures the returned instruction the same cycle into a small fetch FIFO.
- Presents {pc, instr} to decode over a valid/ready handshake.
- Handles branch/jump redirects (flush + retarget) and a halt request.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, fetch FIFO entries (power of 2, >=2).
- NOP_INSTR, 32'h0000_0013, value driven on instr_o when FIFO is empty.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- imem_addr_o  output  32  byte address to instruction memory; equals the internal PC.
- imem_en_o  output  1  fetch enable to instruction memory.
- imem_instr_i  input  32  instruction from memory, combinational, valid in the same cycle as imem_addr_o/imem_en_o.
- redirect_i  input  1  branch/jump taken; flush and retarget.
- redirect_pc_i  input  32  redirect target byte address.
- halt_i  input  1  level request to stop issuing new fetches.
- valid_o  output  1  FIFO head holds a valid instruction.
- ready_i  input  1  decode accepts the head this cycle.
- instr_o  output  32  head instruction (NOP_INSTR when empty).
- pc_o  output  32  byte address of the head instruction (0 when empty).

Behaviour:
- Reset (rst_ni=0, asynchronous): pc=RESET_PC, FIFO empty, count=0, state=WAIT.
  - Outputs during reset: imem_en_o=0, valid_o=0, instr_o=NOP_INSTR, pc_o=0, imem_addr_o=RESET_PC.
- States:
  - WAIT: first cycle after reset release; no fetch. Goes to RUN unconditionally.
  - RUN: fetching. Goes to HALT when halt_i=1.
  - HALT: no fetch; FIFO keeps draining. Returns to RUN when halt_i=0.
  - redirect_i does not change state.
- Fetch rule (combinational): imem_en_o = (state==RUN) && !halt_i && !redirect_i && (count<FIFO_DEPTH).
- On a fetch cycle, at the clock edge:
  - Push {pc, imem_instr_i} into the FIFO.
  - pc <= pc+4. 32-bit wrap: 32'hFFFF_FFFC -> 0.
- Pop: valid_o && ready_i && !redirect_i. Head advances at the clock edge.
- Simultaneous push and pop: count unchanged. With FIFO_DEPTH>=2 this sustains 1 instruction per cycle.
- Full (count==FIFO_DEPTH): no fetch; pc holds. Back-pressure is lossless.
- Empty: valid_o=0, instr_o=NOP_INSTR, pc_o=0. An instruction fetched in cycle N appears on valid_o in cycle N+1 (1-cycle latency).
- Redirect (highest priority, any state except WAIT):
  - At the clock edge: FIFO flushed (count=0, pointers reset), pc <= redirect_pc_i.
  - No push and no pop occur that cycle, even if ready_i=1.
  - Target fetched on the next RUN cycle.
  - Back-to-back redirects: the last one wins.
  - redirect_pc_i[1:0] is ignored; the PC is forced word-aligned ({redirect_pc_i[31:2], 2'b00}).
- Redirect during HALT: flush and pc load still occur; fetching resumes at the new pc once halt_i=0.
- Reset asserted mid-operation: all state returns to reset values immediately; any in-flight FIFO contents are discarded.
- imem_addr_o always equals pc, including cycles where imem_en_o=0.

Optional Feature:
- FETCH_MISALIGN_TRAP_EN
- When defined:
  - Adds output port misalign_o (1 bit) and state TRAP.
  - A redirect with redirect_pc_i[1:0]!=0 causes a flush and sets misalign_o=1 (registered).
  - pc loads the unmodified target, and the state goes to TRAP.
  - TRAP: no fetch; valid_o=0. Only reset, or a subsequent aligned redirect, clears misalign_o and returns to RUN.
- When undefined: no misalign_o port; low bits are silently forced to 00 as above.

Test Plan:
- Reset release, memory preloaded with 0x00500093 at 0x0 and 0x00100113 at 0x4, ready_i=1 -> imem_en_o=0 in WAIT. valid_o rises 2 cycles after release with pc_o=0x0, instr_o=0x00500093; next cycle pc_o=0x4, instr_o=0x00100113.
- ready_i=0 for 5 cycles -> exactly FIFO_DEPTH (2) entries fetched, imem_en_o=0, pc holds 0x8. ready_i=1 -> pops 0x0, 0x4, then 0x8 with no gaps or duplicates.
- Redirect to 0x40 while the FIFO holds 0x8, 0xC and ready_i=1 -> no pop that cycle; next valid instruction has pc_o=0x40. Entries 0x8 and 0xC are never presented.
- halt_i=1 with 2 entries buffered -> imem_en_o=0; both entries drain; then valid_o=0. halt_i=0 -> fetch resumes at the held pc.
- Redirect to 0xFFFF_FFFC -> next fetches go to 0xFFFF_FFFC then 0x0000_0000.
- With FETCH_MISALIGN_TRAP_EN: redirect to 0x42 -> misalign_o=1, valid_o=0, no fetch. Redirect to 0x80 -> misalign_o=0, fetch from 0x80.
